// File: rtl/vpg_pkg.sv
// Shared types and constants for the video pattern source: FSM states,
// register map, pattern codes, packet type nibbles and the colour-bar table.
package vpg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_DATA,
    VID_HDR,
    VID_PIX,
    GAP
  } state_t;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_ID     = 4'd2;
  localparam logic [3:0] ADDR_FG     = 4'd3;
  localparam logic [3:0] ADDR_BG     = 4'd4;
  localparam logic [3:0] ADDR_BOX_TL = 4'd5;
  localparam logic [3:0] ADDR_BOX_BR = 4'd6;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_BOX   = 2'd2;
  localparam logic [1:0] PAT_RAMP  = 2'd3;

  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  // Frame configuration as frozen at frame start
  typedef struct packed {
    logic [1:0]  pattern;
    logic [23:0] fg;
    logic [23:0] bg;
    logic [10:0] tl_x;
    logic [10:0] tl_y;
    logic [10:0] br_x;
    logic [10:0] br_y;
  } cfg_t;

  // Index 8 and above is the black filler past the last full bar
  function automatic logic [23:0] bar_colour(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'd0:    c = 24'hFFFFFF;
      4'd1:    c = 24'hFFFF00;
      4'd2:    c = 24'h00FFFF;
      4'd3:    c = 24'h00FF00;
      4'd4:    c = 24'hFF00FF;
      4'd5:    c = 24'hFF0000;
      4'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vpg_pattern.sv
// Combinational pixel generator: maps a raster position and bar index to an
// RGB value using the frozen frame configuration.
module vpg_pattern
  import vpg_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [3:0]  bar_idx,
  input  cfg_t        cfg,
  output logic [23:0] rgb
);

  logic in_box;

  always_comb begin
    // An inverted box (TL past BR on either axis) can never satisfy both bounds
    in_box = (x >= cfg.tl_x) && (x <= cfg.br_x) &&
             (y >= cfg.tl_y) && (y <= cfg.br_y);
    rgb = '0;
    case (cfg.pattern)
      PAT_BARS:  rgb = bar_colour(bar_idx);
      PAT_SOLID: rgb = cfg.fg;
      PAT_BOX:   rgb = in_box ? cfg.fg : cfg.bg;
      PAT_RAMP:  rgb = {3{x[7:0]}};
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST RGB test-pattern transmitter (control packet + video packet per
// frame) with an Avalon-MM configuration slave.
module video_pattern_source
  import vpg_pkg::*;
#(
  parameter int unsigned IMAGE_W    = 640,
  parameter int unsigned IMAGE_H    = 480,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [31:0] ID_VALUE   = 32'h1234EEE3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [3:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop
);

  localparam logic [15:0] W16       = 16'(IMAGE_W);
  localparam logic [15:0] H16       = 16'(IMAGE_H);
  localparam logic [10:0] X_LAST    = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST    = 11'(IMAGE_H - 1);
  localparam int unsigned BAR_W     = IMAGE_W / 8;
  localparam logic [10:0] BAR_LAST  = 11'((BAR_W == 0) ? 0 : BAR_W - 1);
  localparam logic [3:0]  BAR_START = (BAR_W == 0) ? 4'd8 : 4'd0;
  localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic        ONE_PIXEL = (X_LAST == '0) && (Y_LAST == '0);

  localparam logic [23:0] CBEAT1 = {4'h0, W16[7:4],   4'h0, W16[11:8],  4'h0, W16[15:12]};
  localparam logic [23:0] CBEAT2 = {4'h0, H16[11:8],  4'h0, H16[15:12], 4'h0, W16[3:0]};
  localparam logic [23:0] CBEAT3 = {4'h0, 4'h3,       4'h0, H16[3:0],   4'h0, H16[7:4]};

  state_t      state_q, state_d;
  logic [1:0]  cbeat_q, cbeat_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [3:0]  bar_idx_q, bar_idx_d;
  logic [15:0] gap_q, gap_d;
  cfg_t        shadow_q, shadow_d;
  logic        valid_d, sop_d, eop_d;
  logic [23:0] data_d;
  logic        frame_done;

  logic [3:0]  ctrl_q;
  logic [23:0] fg_q, bg_q;
  logic [10:0] tl_x_q, tl_y_q, br_x_q, br_y_q;
  logic [15:0] frame_count_q;
  logic        busy;
  logic        wr_en;
  logic        unused_wdata;

  logic [10:0] nx, ny, nbar_cnt;
  logic [3:0]  nbar_idx;
  logic        next_last;
  logic [10:0] pix_x, pix_y;
  logic [3:0]  pix_bar;
  logic [23:0] pix_rgb;
  logic        fire;

  assign fire         = source_valid & source_ready;
  assign busy         = (state_q != IDLE);
  assign wr_en        = s_chipselect & s_write;
  assign unused_wdata = ^s_writedata[31:27];

  // Raster position of the beat after the one currently presented
  always_comb begin
    nx       = x_q + 11'd1;
    ny       = y_q;
    nbar_cnt = bar_cnt_q;
    nbar_idx = bar_idx_q;
    if (x_q == X_LAST) begin
      nx       = '0;
      ny       = y_q + 11'd1;
      nbar_cnt = '0;
      nbar_idx = BAR_START;
    end else if (bar_idx_q < 4'd8) begin
      if (bar_cnt_q == BAR_LAST) begin
        nbar_cnt = '0;
        nbar_idx = bar_idx_q + 4'd1;
      end else begin
        nbar_cnt = bar_cnt_q + 11'd1;
      end
    end
    next_last = (nx == X_LAST) && (ny == Y_LAST);
  end

  always_comb begin
    if (state_q == VID_PIX) begin
      pix_x   = nx;
      pix_y   = ny;
      pix_bar = nbar_idx;
    end else begin
      pix_x   = '0;
      pix_y   = '0;
      pix_bar = BAR_START;
    end
  end

  vpg_pattern u_pattern (
    .x       (pix_x),
    .y       (pix_y),
    .bar_idx (pix_bar),
    .cfg     (shadow_q),
    .rgb     (pix_rgb)
  );

  // Next-state logic preloads the output register with the following beat,
  // so the ready input only ever reaches flop D pins.
  always_comb begin
    state_d    = state_q;
    cbeat_d    = cbeat_q;
    x_d        = x_q;
    y_d        = y_q;
    bar_cnt_d  = bar_cnt_q;
    bar_idx_d  = bar_idx_q;
    gap_d      = gap_q;
    shadow_d   = shadow_q;
    valid_d    = source_valid;
    data_d     = source_data;
    sop_d      = source_sop;
    eop_d      = source_eop;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (ctrl_q[0]) begin
          shadow_d = '{pattern: ctrl_q[2:1], fg: fg_q, bg: bg_q,
                       tl_x: tl_x_q, tl_y: tl_y_q, br_x: br_x_q, br_y: br_y_q};
          state_d  = CTRL_HDR;
          valid_d  = 1'b1;
          data_d   = {20'h0, PKT_CTRL};
          sop_d    = 1'b1;
          eop_d    = 1'b0;
        end
      end
      CTRL_HDR: begin
        if (fire) begin
          state_d = CTRL_DATA;
          cbeat_d = '0;
          data_d  = CBEAT1;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
        end
      end
      CTRL_DATA: begin
        if (fire) begin
          if (cbeat_q == 2'd2) begin
            state_d = VID_HDR;
            data_d  = {20'h0, PKT_VIDEO};
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            cbeat_d = cbeat_q + 2'd1;
            data_d  = (cbeat_q == 2'd0) ? CBEAT2 : CBEAT3;
            eop_d   = (cbeat_q == 2'd1);
          end
        end
      end
      VID_HDR: begin
        if (fire) begin
          state_d   = VID_PIX;
          x_d       = '0;
          y_d       = '0;
          bar_cnt_d = '0;
          bar_idx_d = BAR_START;
          data_d    = pix_rgb;
          sop_d     = 1'b0;
          eop_d     = ONE_PIXEL;
        end
      end
      VID_PIX: begin
        if (fire) begin
          if (source_eop) begin
            state_d    = GAP;
            gap_d      = '0;
            valid_d    = 1'b0;
            data_d     = '0;
            eop_d      = 1'b0;
            frame_done = 1'b1;
          end else begin
            x_d       = nx;
            y_d       = ny;
            bar_cnt_d = nbar_cnt;
            bar_idx_d = nbar_idx;
            data_d    = pix_rgb;
            eop_d     = next_last;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cbeat_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      bar_cnt_q    <= '0;
      bar_idx_q    <= '0;
      gap_q        <= '0;
      shadow_q     <= '0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cbeat_q      <= cbeat_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_cnt_q    <= bar_cnt_d;
      bar_idx_q    <= bar_idx_d;
      gap_q        <= gap_d;
      shadow_q     <= shadow_d;
      source_valid <= valid_d;
      source_data  <= data_d;
      source_sop   <= sop_d;
      source_eop   <= eop_d;
    end
  end

  // CPU write to CTRL takes priority over the single-shot self-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= '0;
      fg_q          <= 24'hFF0000;
      bg_q          <= '0;
      tl_x_q        <= '0;
      tl_y_q        <= '0;
      br_x_q        <= '0;
      br_y_q        <= '0;
      frame_count_q <= '0;
      s_readdata    <= '0;
    end else begin
      if (frame_done) frame_count_q <= frame_count_q + 16'd1;
      if (wr_en && (s_address == ADDR_CTRL)) ctrl_q <= s_writedata[3:0];
      else if (frame_done && ctrl_q[3])      ctrl_q[0] <= 1'b0;
      if (wr_en) begin
        case (s_address)
          ADDR_FG: fg_q <= s_writedata[23:0];
          ADDR_BG: bg_q <= s_writedata[23:0];
          ADDR_BOX_TL: begin
            tl_x_q <= s_writedata[26:16];
            tl_y_q <= s_writedata[10:0];
          end
          ADDR_BOX_BR: begin
            br_x_q <= s_writedata[26:16];
            br_y_q <= s_writedata[10:0];
          end
          default: ;
        endcase
      end
      if (s_chipselect && s_read) begin
        case (s_address)
          ADDR_CTRL:   s_readdata <= {28'h0, ctrl_q};
          ADDR_STATUS: s_readdata <= {15'h0, busy, frame_count_q};
          ADDR_ID:     s_readdata <= ID_VALUE;
          ADDR_FG:     s_readdata <= {8'h0, fg_q};
          ADDR_BG:     s_readdata <= {8'h0, bg_q};
          ADDR_BOX_TL: s_readdata <= {5'h0, tl_x_q, 5'h0, tl_y_q};
          ADDR_BOX_BR: s_readdata <= {5'h0, br_x_q, 5'h0, br_y_q};
          default:     s_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source on a reduced 20x6 raster:
// every transferred beat is compared with a frame list built from the pattern rules.
module tb_video_pattern_source;

  localparam int W   = 20;
  localparam int H   = 6;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [3:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready = 1'b1;

  video_pattern_source #(
    .IMAGE_W    (W),
    .IMAGE_H    (H),
    .GAP_CYCLES (GAP),
    .ID_VALUE   (32'h1234EEE3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic [1:0]  pat;
    logic [23:0] fg;
    logic [23:0] bg;
    int          tlx, tly, brx, bry;
    int          idx;
    logic [23:0] px;
    int          fg_cnt;
  } vec_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stall_pct = 0;
  logic        mon_en = 1'b0;
  int          eop_cnt = 0;
  logic [23:0] vid [W*H];
  int          pix_idx = 0;
  bit          in_vid = 0;
  bit          prev_stall = 0;
  logic [25:0] prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_ref(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] ref_pixel(input int pat, input logic [23:0] fg, input logic [23:0] bg,
                                            input int tlx, input int tly, input int brx, input int bry,
                                            input int x, input int y);
    int bw;
    int r;
    bw = W / 8;
    case (pat)
      0: return (bw > 0 && x < 8 * bw) ? bar_ref(x / bw) : 24'h000000;
      1: return fg;
      2: return (x >= tlx && x <= brx && y >= tly && y <= bry) ? fg : bg;
      default: begin
        r = x % 256;
        return 24'(r * 65536 + r * 256 + r);
      end
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] fg, input logic [23:0] bg,
                            input int tlx, input int tly, input int brx, input int bry);
    int b1, b2, b3;
    b1 = (((W >> 4) & 15) << 16) | (((W >> 8) & 15) << 8) | ((W >> 12) & 15);
    b2 = (((H >> 8) & 15) << 16) | (((H >> 12) & 15) << 8) | (W & 15);
    b3 = (3 << 16) | ((H & 15) << 8) | ((H >> 4) & 15);
    exp_q.push_back('{24'h00000F, 1'b1, 1'b0});
    exp_q.push_back('{24'(b1), 1'b0, 1'b0});
    exp_q.push_back('{24'(b2), 1'b0, 1'b0});
    exp_q.push_back('{24'(b3), 1'b0, 1'b1});
    exp_q.push_back('{24'h000000, 1'b1, 1'b0});
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back('{ref_pixel(pat, fg, bg, tlx, tly, brx, bry, x, y), 1'b0,
                          (x == W - 1 && y == H - 1)});
  endtask

  always @(posedge clk) begin
    #1;
    source_ready = (int'($urandom_range(0, 99)) >= stall_pct);
  end

  always @(negedge clk) begin
    beat_t e;
    if (!mon_en) begin
      prev_stall = 0;
      in_vid = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {5'h0, source_valid, source_sop, source_eop, source_data},
              {5'h0, 1'b1, prev_beat});
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", source_data);
        end else begin
          e = exp_q.pop_front();
          check("beat", {6'h0, source_sop, source_eop, source_data}, {6'h0, e.sop, e.eop, e.data});
        end
        if (source_sop) begin
          in_vid  = (source_data == 24'h000000);
          pix_idx = 0;
        end else if (in_vid && pix_idx < W * H) begin
          vid[pix_idx] = source_data;
          pix_idx++;
        end
        if (source_eop) eop_cnt++;
      end
      prev_stall = source_valid && !source_ready;
      prev_beat  = {source_sop, source_eop, source_data};
    end
  end

  task automatic mm_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic mm_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mm_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_eops(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (eop_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(eop_cnt >= target), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t tbl[9];
  int   fc;
  int   base;
  int   cnt;

  initial begin
    tbl[0] = '{2'd0, 24'hFFFFFF, 24'h000000, 0, 0, 0, 0,  2, 24'hFFFF00, 12};
    tbl[1] = '{2'd0, 24'hFF0000, 24'h000000, 0, 0, 0, 0, 30, 24'hFF0000, 12};
    tbl[2] = '{2'd0, 24'h000000, 24'h000000, 0, 0, 0, 0, 75, 24'h000000, 36};
    tbl[3] = '{2'd1, 24'h123456, 24'h000000, 0, 0, 0, 0,  0, 24'h123456, 120};
    tbl[4] = '{2'd2, 24'h00FF00, 24'h000080, 3, 1, 7, 4, 23, 24'h00FF00, 20};
    tbl[5] = '{2'd2, 24'h00FF00, 24'h000080, 3, 1, 7, 4, 88, 24'h000080, 20};
    tbl[6] = '{2'd2, 24'h00FF00, 24'h000080, 7, 1, 3, 4, 25, 24'h000080, 0};
    tbl[7] = '{2'd2, 24'h00FF00, 24'h000080, 3, 4, 7, 1, 63, 24'h000080, 0};
    tbl[8] = '{2'd3, 24'h0D0D0D, 24'h000000, 0, 0, 0, 0, 53, 24'h0D0D0D, 6};

    // Reset state and register map
    idle_cycles(3);
    check("reset_outputs", {7'h0, source_valid, source_sop, source_eop, source_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    check("reset_readdata", s_readdata, 32'h0);
    read_check("ctrl_reset", 4'd0, 32'h0);
    read_check("status_reset", 4'd1, 32'h0);
    read_check("id", 4'd2, 32'h1234EEE3);
    read_check("fg_reset", 4'd3, 32'h00FF0000);
    read_check("bg_reset", 4'd4, 32'h0);
    read_check("tl_reset", 4'd5, 32'h0);
    read_check("br_reset", 4'd6, 32'h0);
    mm_write(4'd2, 32'hDEADBEEF);
    mm_write(4'd9, 32'hFFFFFFFF);
    read_check("id_ro", 4'd2, 32'h1234EEE3);
    read_check("unmapped", 4'd9, 32'h0);
    mm_write(4'd5, {5'h0, 11'd1234, 5'h0, 11'd567});
    read_check("tl_rw", 4'd5, {5'h0, 11'd1234, 5'h0, 11'd567});
    idle_cycles(3);
    check("idle_valid", {31'h0, source_valid}, 32'h0);

    // Single-shot frames from the vector table, odd rows with 30% stalls
    fc = 0;
    foreach (tbl[i]) begin
      stall_pct = (i % 2 == 1) ? 30 : 0;
      mm_write(4'd3, {8'h0, tbl[i].fg});
      mm_write(4'd4, {8'h0, tbl[i].bg});
      mm_write(4'd5, {5'h0, 11'(tbl[i].tlx), 5'h0, 11'(tbl[i].tly)});
      mm_write(4'd6, {5'h0, 11'(tbl[i].brx), 5'h0, 11'(tbl[i].bry)});
      push_frame(int'(tbl[i].pat), tbl[i].fg, tbl[i].bg, tbl[i].tlx, tbl[i].tly, tbl[i].brx, tbl[i].bry);
      base = eop_cnt;
      mm_write(4'd0, {28'h0, 1'b1, tbl[i].pat, 1'b1});
      wait_eops("frame_done", base + 2, 2000);
      fc++;
      cnt = 0;
      for (int k = 0; k < W * H; k++) if (vid[k] == tbl[i].fg) cnt++;
      check("fg_count", 32'(cnt), 32'(tbl[i].fg_cnt));
      check("pixel", {8'h0, vid[tbl[i].idx]}, {8'h0, tbl[i].px});
      idle_cycles(GAP + 6);
      read_check("ctrl_selfclear", 4'd0, {28'h0, 1'b1, tbl[i].pat, 1'b0});
      read_check("status_after", 4'd1, {15'h0, 1'b0, 16'(fc)});
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      check("valid_low", {31'h0, source_valid}, 32'h0);
    end

    // Pattern change mid-frame only affects the next frame; disable completes the frame
    stall_pct = 0;
    mm_write(4'd3, 32'h00ABCDEF);
    push_frame(1, 24'hABCDEF, 24'h000080, 0, 0, 0, 0);
    base = eop_cnt;
    mm_write(4'd0, 32'h3);
    wait_eops("cont_ctrl_pkt", base + 1, 200);
    idle_cycles(10);
    mm_write(4'd0, 32'h1);
    push_frame(0, 24'hABCDEF, 24'h000080, 0, 0, 0, 0);
    wait_eops("cont_frame2_ctrl", base + 3, 2000);
    mm_write(4'd0, 32'h0);
    wait_eops("cont_frame2_done", base + 4, 2000);
    fc += 2;
    check("bars_col2", {8'h0, vid[2]}, 32'h00FFFF00);
    check("bars_col19", {8'h0, vid[W - 1]}, 32'h0);
    idle_cycles(GAP + 10);
    check("cont_drained", 32'(exp_q.size()), 32'h0);
    read_check("cont_status", 4'd1, {15'h0, 1'b0, 16'(fc)});

    // Asynchronous reset in the middle of the pixel stream
    push_frame(1, 24'hABCDEF, 24'h000080, 0, 0, 0, 0);
    base = eop_cnt;
    mm_write(4'd0, 32'h3);
    wait_eops("rst_ctrl_pkt", base + 1, 200);
    idle_cycles(20);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    check("async_valid", {31'h0, source_valid}, 32'h0);
    exp_q.delete();
    idle_cycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    read_check("rst_status", 4'd1, 32'h0);
    read_check("rst_ctrl", 4'd0, 32'h0);
    push_frame(1, 24'hFF0000, 24'h000000, 0, 0, 0, 0);
    base = eop_cnt;
    mm_write(4'd0, 32'hB);
    wait_eops("rst_restart", base + 2, 2000);
    idle_cycles(GAP + 6);
    read_check("rst_count", 4'd1, 32'h1);
    check("rst_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
